// File: rtl/gm_pkg.sv
// rtl/gm_pkg.sv - shared constants and key-code type for GameManager input logic
//
// Purpose: widths and defaults shared by the button front end and the
// GameManager pattern compare.
package gm_pkg;

    localparam int KEY_W            = 3;
    localparam int NUM_BTN          = 8;
    localparam int DEBOUNCE_DEFAULT = 10000;

    // Button index 0..7; the pattern compare uses the same type.
    typedef logic [KEY_W-1:0] key_code_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus counter debounce for one button
//
// Purpose: produce a clean level from one raw, asynchronous button input.
// Ports:
//   clk_2     - system clock
//   rst_n     - asynchronous active-low reset
//   raw_i     - raw button, active-high, asynchronous to clk_2
//   level_o   - debounced level; changes only after DEBOUNCE_CYCLES stable cycles
module btn_debounce
    import gm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 14
) (
    input  logic clk_2,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter measures how long the synced input has disagreed with the
    // current level; any agreement restarts it, so bounces never get through.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/button_event_encoder.sv
// rtl/button_event_encoder.sv - debounced button presses to a queue of key events
//
// Purpose: one key event per physical press, in press order, popped through
// a valid/ready handshake.
// Ports:
//   clk_2, rst_n  - clock, asynchronous active-low reset
//   btn_raw       - 8 raw buttons, active-high
//   enable        - high during the player-input phase; low flushes the queue
//   key_valid     - head event available
//   key_code      - button index of the head event
//   key_ready     - consumer accepts the head event
//   btn_level     - debounced levels
//   overflow      - sticky, an event was dropped on a full queue
//   clr_overflow  - synchronous clear of overflow
module button_event_encoder
    import gm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 14,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clk_2,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               enable,
    output logic               key_valid,
    output logic [KEY_W-1:0]   key_code,
    input  logic               key_ready,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               overflow,
    input  logic               clr_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;
    localparam logic [CNT_FW-1:0] FULL_COUNT = CNT_FW'(FIFO_DEPTH);

    // ---------------- debounce ----------------
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk_2   (clk_2),
            .rst_n   (rst_n),
            .raw_i   (btn_raw[g]),
            .level_o (btn_level[g])
        );
    end

    // ---------------- press detect and arbiter ----------------
    logic [NUM_BTN-1:0] level_prev_q;
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] cand;
    logic               push_req;
    key_code_t          push_code;

    // A rise is offered to the arbiter in the same cycle it is seen, so a
    // lone press reaches the queue one cycle after the level changes.
    assign rise = btn_level & ~level_prev_q;
    assign cand = enable ? (pending_q | rise) : '0;

    always_comb begin
        push_req  = 1'b0;
        push_code = '0;
        // Descending scan leaves the lowest set index as the winner.
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (cand[i]) begin
                push_req  = 1'b1;
                push_code = key_code_t'(i);
            end
        end
        // The winner leaves pending whether it is queued or dropped.
        pending_d = cand & ~(NUM_BTN'(1) << push_code);
        if (!push_req) begin
            pending_d = cand;
        end
    end

    // ---------------- event FIFO ----------------
    key_code_t         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              full, pop, push_ok, drop;

    assign full    = (count_q == FULL_COUNT);
    assign pop     = key_valid && key_ready;
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!enable) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // A drop in the same cycle as a clear wins, so no drop goes unreported.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q <= '0;
            pending_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_prev_q <= btn_level;
            pending_q    <= pending_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            if (enable && push_ok) begin
                mem_q[wr_ptr_q] <= push_code;
            end
        end
    end

    // Outputs depend only on registers, so the head stays stable while stalled.
    assign key_valid = (count_q != '0);
    assign key_code  = key_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow  = overflow_q;

endmodule
